// File: rtl/load_align.sv
// load_align: load unit that fetches a word and aligns/sign-controls the byte, halfword or word for writeback
// Optional feature: define LOAD_MISALIGN_TRAP_EN to trap misaligned LH/LHU/LW without a memory access.
module load_align #(
   parameter int ACK_TIMEOUT = 255
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        ld_valid,
   output logic        ld_ready,
   input  logic [31:0] ld_addr,
   input  logic [2:0]  ld_op,
   output logic        dm_req,
   output logic [31:0] dm_addr,
   input  logic        dm_ack,
   input  logic [31:0] dm_rdata,
   output logic        res_valid,
   input  logic        res_ready,
   output logic [15:0] res_lane,
   output logic        res_sign_ext,
   output logic [31:0] res_word,
   output logic        res_is_word,
   output logic        res_err
);
   typedef enum logic [1:0] {IDLE, REQ, RESP} state_t;
   state_t      state_q, state_d;
   logic [7:0]  cnt_q, cnt_d;
   logic [1:0]  off_q, off_d;
   logic [2:0]  op_q, op_d;
   logic        dm_req_q, dm_req_d;
   logic [31:0] dm_addr_q, dm_addr_d;
   logic        res_valid_q, res_valid_d;
   logic [15:0] res_lane_q, res_lane_d;
   logic        res_sign_ext_q, res_sign_ext_d;
   logic [31:0] res_word_q, res_word_d;
   logic        res_is_word_q, res_is_word_d;
   logic        res_err_q, res_err_d;
   logic [7:0]  sel_b;
   logic [15:0] sel_h;
   logic        is_w, is_h, sx, trap;
   assign ld_ready     = (state_q == IDLE);
   assign dm_req       = dm_req_q;
   assign dm_addr      = dm_addr_q;
   assign res_valid    = res_valid_q;
   assign res_lane     = res_lane_q;
   assign res_sign_ext = res_sign_ext_q;
   assign res_word     = res_word_q;
   assign res_is_word  = res_is_word_q;
   assign res_err      = res_err_q;
   // Next-state logic: accept, wait for ack or timeout, then hold the result until consumed
   always_comb begin
      state_d        = state_q;
      cnt_d          = cnt_q;
      off_d          = off_q;
      op_d           = op_q;
      dm_req_d       = dm_req_q;
      dm_addr_d      = dm_addr_q;
      res_valid_d    = res_valid_q;
      res_lane_d     = res_lane_q;
      res_sign_ext_d = res_sign_ext_q;
      res_word_d     = res_word_q;
      res_is_word_d  = res_is_word_q;
      res_err_d      = res_err_q;
      sel_b          = dm_rdata[{off_q, 3'b000} +: 8];
      sel_h          = off_q[1] ? dm_rdata[31:16] : dm_rdata[15:0];
      is_w           = op_q[2];
      is_h           = (op_q[2:1] == 2'b01);
      sx             = ~op_q[2] & ~op_q[0];
`ifdef LOAD_MISALIGN_TRAP_EN
      trap           = (ld_op[2] && ld_addr[1:0] != 2'b00) || (ld_op[2:1] == 2'b01 && ld_addr[0]);
`else
      trap           = 1'b0;
`endif
      unique case (state_q)
         IDLE: if (ld_valid) begin
            op_d      = ld_op;
            off_d     = ld_addr[1:0];
            dm_addr_d = {ld_addr[31:2], 2'b00};
            cnt_d     = 8'd0;
            if (trap) begin
               state_d        = RESP;
               res_valid_d    = 1'b1;
               res_err_d      = 1'b1;
               res_lane_d     = 16'd0;
               res_word_d     = 32'd0;
               res_sign_ext_d = 1'b0;
               res_is_word_d  = 1'b0;
            end else begin
               state_d  = REQ;
               dm_req_d = 1'b1;
            end
         end
         REQ: if (dm_ack) begin
            state_d        = RESP;
            dm_req_d       = 1'b0;
            res_valid_d    = 1'b1;
            res_err_d      = 1'b0;
            res_word_d     = dm_rdata;
            res_is_word_d  = is_w;
            res_sign_ext_d = sx;
            res_lane_d     = is_w ? dm_rdata[15:0] : is_h ? sel_h : {{8{sx & sel_b[7]}}, sel_b};
         end else if (cnt_q == 8'(ACK_TIMEOUT - 1)) begin
            state_d        = RESP;
            dm_req_d       = 1'b0;
            res_valid_d    = 1'b1;
            res_err_d      = 1'b1;
            res_lane_d     = 16'd0;
            res_word_d     = 32'd0;
            res_sign_ext_d = 1'b0;
            res_is_word_d  = 1'b0;
         end else begin
            cnt_d = cnt_q + 8'd1;
         end
         RESP: if (res_ready) begin
            state_d     = IDLE;
            res_valid_d = 1'b0;
         end
         default: state_d = IDLE;
      endcase
   end
   // State and registered outputs; reset drops any in-flight load
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q        <= IDLE;
         cnt_q          <= 8'd0;
         off_q          <= 2'd0;
         op_q           <= 3'd0;
         dm_req_q       <= 1'b0;
         dm_addr_q      <= 32'd0;
         res_valid_q    <= 1'b0;
         res_lane_q     <= 16'd0;
         res_sign_ext_q <= 1'b0;
         res_word_q     <= 32'd0;
         res_is_word_q  <= 1'b0;
         res_err_q      <= 1'b0;
      end else begin
         state_q        <= state_d;
         cnt_q          <= cnt_d;
         off_q          <= off_d;
         op_q           <= op_d;
         dm_req_q       <= dm_req_d;
         dm_addr_q      <= dm_addr_d;
         res_valid_q    <= res_valid_d;
         res_lane_q     <= res_lane_d;
         res_sign_ext_q <= res_sign_ext_d;
         res_word_q     <= res_word_d;
         res_is_word_q  <= res_is_word_d;
         res_err_q      <= res_err_d;
      end
   end
endmodule

// File: doc/load_align.md
LOAD_ALIGN -- requirements
Module: load_align

Interface
REQ-001 SHALL have parameter ACK_TIMEOUT, default 255, meaning the maximum number of cycles to wait for dm_ack before a bus error (legal range 1..255).
REQ-002 SHALL have port clk, input, 1 bit, the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n, input, 1 bit, asynchronous active-low reset.
REQ-004 SHALL have port ld_valid, input, 1 bit, load request from the MEM stage.
REQ-005 SHALL have port ld_ready, output, 1 bit, block can accept a load.
REQ-006 SHALL have port ld_addr, input, 32 bits, byte address of the load.
REQ-007 SHALL have port ld_op, input, 3 bits: 000 LB, 001 LBU, 010 LH, 011 LHU, 100 LW; 101-111 are treated as LW.
REQ-008 SHALL have port dm_req, output, 1 bit, data-memory read request.
REQ-009 SHALL have port dm_addr, output, 32 bits, word-aligned address with bits [1:0] equal to 00.
REQ-010 SHALL have port dm_ack, input, 1 bit, memory read-data-valid strobe.
REQ-011 SHALL have port dm_rdata, input, 32 bits, memory read word.
REQ-012 SHALL have port res_valid, output, 1 bit, result available.
REQ-013 SHALL have port res_ready, input, 1 bit, consumer (the 16-to-32 extender/writeback) accepts the result.
REQ-014 SHALL have port res_lane, output, 16 bits, halfword or byte field for the extender.
REQ-015 SHALL have port res_sign_ext, output, 1 bit, sign-extension control for the extender.
REQ-016 SHALL have port res_word, output, 32 bits, full word for LW.
REQ-017 SHALL have port res_is_word, output, 1 bit, result is a word load (writeback uses res_word and bypasses the extender).
REQ-018 SHALL have port res_err, output, 1 bit, bus timeout or misalignment.

Function
REQ-019 SHALL implement an FSM with states IDLE, REQ and RESP, where ld_ready=1 only in IDLE.
REQ-020 SHALL, in IDLE with ld_valid=1, capture ld_addr and ld_op and go to REQ on the same edge.
REQ-021 SHALL, in REQ, drive dm_req=1 with dm_addr={addr[31:2],2'b00} and increment a wait counter each cycle.
REQ-022 SHALL, when dm_ack=1 in REQ, capture dm_rdata, drop dm_req and go to RESP; the fastest path is res_valid 2 cycles after acceptance.
REQ-023 SHALL, when the wait counter reaches ACK_TIMEOUT without dm_ack, go to RESP with res_err=1 and res_lane=0, res_word=0; a dm_ack arriving in the same cycle as the timeout wins (no error).
REQ-024 SHALL assert res_valid only in RESP and hold all res_* outputs stable until res_valid&res_ready, then return to IDLE; a new load is accepted no earlier than the following cycle.
REQ-025 SHALL use little-endian lanes: byte offset 0 is dm_rdata[7:0]; for halfwords, addr[1]=0 selects [15:0] and addr[1]=1 selects [31:16].
REQ-026 SHALL, for LB/LBU, set res_lane={8{s&b[7]},b}, where b is the selected byte and s is 1 for LB, 0 for LBU.
REQ-027 SHALL, for LH/LHU, set res_lane to the selected halfword unchanged.
REQ-028 SHALL set res_sign_ext=1 for LB and LH, else 0.
REQ-029 SHALL, for LW, set res_word=dm_rdata, res_is_word=1 and res_lane=dm_rdata[15:0].
REQ-030 SHALL ignore dm_ack outside REQ.

Reset
REQ-031 SHALL, on rst_n low (asynchronous), enter IDLE and clear the counter, dm_req, dm_addr, res_valid, res_lane, res_word, res_sign_ext, res_is_word and res_err to 0, so that ld_ready=1 once reset is released.
REQ-032 SHALL drop any in-flight load when reset is asserted mid-operation, and SHALL ignore a late dm_ack after release.

Configuration
REQ-033 SHALL, with LOAD_MISALIGN_TRAP_EN defined, complete a misaligned LH/LHU (addr[0]=1) or LW (addr[1:0]!=0) without issuing dm_req: IDLE goes to RESP next cycle with res_err=1 and data outputs 0.
REQ-034 SHALL, without LOAD_MISALIGN_TRAP_EN, ignore addr[0] for halfwords and addr[1:0] for words, so misalignment never raises res_err.

Verification
REQ-035 SHALL cover: LB at addr 0x103, dm_rdata 0x80FF1234, ack after 1 cycle -> res_lane 0xFF80, res_sign_ext 1, dm_addr 0x100.
REQ-036 SHALL cover: LHU at addr 0x202, dm_rdata 0xBEEF0001 -> res_lane 0xBEEF, res_sign_ext 0, res_is_word 0.
REQ-037 SHALL cover: LW at addr 0x10, dm_ack withheld, ACK_TIMEOUT=4 -> res_err 1 after 4 REQ cycles, then dm_req 0.
REQ-038 SHALL cover: LW, dm_rdata 0x12345678, res_ready held 0 for 3 cycles -> res_valid and res_word 0x12345678 stable, ld_ready 0 throughout.
REQ-039 SHALL cover: LH at addr 0x11 -> with LOAD_MISALIGN_TRAP_EN defined, res_err 1 and dm_req never asserted; without it, res_lane is taken from [15:0].
REQ-040 SHALL cover: rst_n pulsed low during REQ, then a late dm_ack -> outputs 0, IDLE, res_valid stays 0.
